handshake_receiver: RTL and testbench
=====================================

# handshake_receiver

Receiving end of the four-phase validdata/acknowledge handshake used by the team's stimulus generators. It samples `validdata` and its data word, writes the word into a small FIFO, and raises `acknowledge` after a programmable delay. It holds `acknowledge` until the sender drops `validdata`. Downstream logic drains the FIFO through a simple read port. Protocol violations by the sender are flagged.

## Interface
- `DATA_W`, default 8: data word width.
- `DEPTH`, default 4: FIFO depth; must be a power of 2, ≥2.
- `ACK_DELAY`, default 2: cycles from capture edge to `acknowledge` rising; ≥1.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `validdata`  in  1  sender request; level, four-phase.
- `data_in`  in  `DATA_W`  sender data; valid while `validdata`=1.
- `acknowledge`  out  1  registered handshake response.
- `rd_en`  in  1  downstream read request.
- `dout`  out  `DATA_W`  registered read data.
- `empty`  out  1  FIFO count = 0.
- `full`  out  1  FIFO count = `DEPTH`.
- `count`  out  clog2(`DEPTH`)+1  current FIFO occupancy.
- `proto_err`  out  1  sticky protocol-violation flag.

## Operation
The block is a three-state FSM: IDLE, DELAY, ACK.

- **IDLE**
  - `validdata`=1 and `full`=0 at an edge:
    - Write `data_in` to `mem[wptr]`, then increment `wptr` (wraps modulo `DEPTH`).
    - Load `cnt` = `ACK_DELAY`-1 and go to DELAY.
  - `validdata`=1 and `full`=1: no write; stay in IDLE with `acknowledge`=0 (backpressure).
- **DELAY**
  - `validdata`=0: set `proto_err`=1, go to IDLE, and leave `acknowledge` low. The captured word stays in the FIFO.
  - Otherwise, `cnt`=0: `acknowledge` goes to 1 and the FSM goes to ACK. Any other `cnt`: decrement `cnt`.
- **ACK**
  - `acknowledge` is held at 1 while `validdata`=1.
  - `validdata` sampled 0: `acknowledge` goes to 0 and the FSM goes to IDLE.
- **Read port**
  - `rd_en`=1 and `empty`=0: `dout` takes `mem[rptr]`, `rptr` increments with wrap, and `count` decrements.
  - `rd_en` while empty is ignored: `dout` holds and nothing underflows.
- **Simultaneous events**
  - Write and read in the same edge: `count` is unchanged and pointers advance independently.
  - The full check uses `count` before the edge, so a read in the same cycle does not free a slot for that cycle's capture. The capture is retried on the next edge.
- `full`, `empty` and `count` derive from one registered occupancy counter and are always mutually consistent.
- `proto_err` clears only on reset.

## Timing
- Reset (`rst`=0, asynchronous): immediately, with no clock edge needed:
  - FSM in IDLE; `acknowledge`=0, `proto_err`=0.
  - `wptr`=`rptr`=0, `count`=0, `empty`=1, `full`=0, `dout`=0.
  - `mem` is not cleared.
- Reset release is synchronous to the next rising edge. Reset mid-handshake aborts the handshake; the sender sees `acknowledge` fall.
- Capture at edge t0 → `acknowledge`=1 after edge t0+`ACK_DELAY`.
- `validdata` sampled 0 at edge tk (in ACK) → `acknowledge`=0 after tk. The next capture can happen at tk+1 at the earliest.
- Minimum full handshake: `ACK_DELAY`+2 cycles.
- `count`, `empty` and `full` update after the capture or read edge. `dout` is valid after the read edge.
- `data_in` is sampled only at the capture edge.

## Test plan
1. **Single transfer.** `ACK_DELAY`=2; `validdata`=1 with `data_in`=0xA5 captured at t0. Required:
   - `acknowledge` rises after t2.
   - Drop `validdata` (sampled 0 at t3): `acknowledge` falls after t3.
   - `count`=1. One `rd_en` → `dout`=0xA5, `empty`=1.
2. **Fill and backpressure.** Four handshakes with 0x01..0x04 and no reads. Required:
   - `full`=1, `count`=4.
   - A fifth `validdata` carrying 0x05 held high keeps `acknowledge`=0.
   - One `rd_en` → `dout`=0x01; 0x05 is captured on the next edge and acknowledged 2 cycles later.
3. **Protocol violation.** Drop `validdata` one cycle after the capture edge with `ACK_DELAY`=2. Required:
   - `proto_err`=1 and `acknowledge` never rises; `count`=1.
   - `proto_err` stays 1 through subsequent good transfers until reset.
4. **Reset mid-ACK.** Assert `rst`=0 between clock edges while `acknowledge`=1 and `count`=3. Required: `acknowledge`=0, `count`=0, `empty`=1, `proto_err`=0 immediately, before the next edge.
5. **Simultaneous read/write.** With `count`=2 holding 0x10,0x11, capture 0x12 on the same edge as `rd_en`. Required:
   - `count` stays 2 and `dout`=0x10.
   - Subsequent reads return 0x11 then 0x12.
6. **Empty read.** Assert `rd_en` after reset for 3 cycles. Required: `dout`=0, `count`=0, `empty`=1 throughout.

Source files
------------

// File: rtl/handshake_receiver.sv
// rtl/handshake_receiver.sv - four-phase validdata/acknowledge receiver feeding a read FIFO
//
// Captures data_in when the sender raises validdata (and the FIFO has room).
// It raises acknowledge ACK_DELAY cycles after the capture edge and holds it
// until validdata drops. Downstream logic drains the words through rd_en/dout.
// A sender that drops validdata before acknowledge sets a sticky proto_err.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   validdata    sender request (level, four-phase)
//   data_in      sender data, sampled only on the capture edge
//   acknowledge  registered handshake response
//   rd_en        downstream read request; ignored while empty
//   dout         registered read data
//   empty/full   occupancy flags
//   count        FIFO occupancy, 0..DEPTH
//   proto_err    sticky protocol-violation flag, cleared only by reset

module handshake_receiver #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int ACK_DELAY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     validdata,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     acknowledge,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (ACK_DELAY > 1) ? $clog2(ACK_DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD   = CNT_W'(ACK_DELAY - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_ACK
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_next;
  logic               ack_next;
  logic               err_set;
  logic               wr_en;
  logic               rd_fire;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;

  // full is the pre-edge occupancy, so a read on the same edge does not
  // make room for this cycle's capture; the sender simply retries next edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt_q;
    ack_next   = 1'b0;
    err_set    = 1'b0;
    wr_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (validdata && !full) begin
          wr_en      = 1'b1;
          cnt_next   = CNT_LOAD;
          state_next = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!validdata) begin
          // Early withdrawal: the captured word stays in the FIFO.
          err_set    = 1'b1;
          state_next = ST_IDLE;
        end else if (cnt_q == '0) begin
          ack_next   = 1'b1;
          state_next = ST_ACK;
        end else begin
          cnt_next = cnt_q - CNT_W'(1);
        end
      end
      ST_ACK: begin
        if (validdata) begin
          ack_next = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      cnt_q       <= '0;
      acknowledge <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      state       <= state_next;
      cnt_q       <= cnt_next;
      acknowledge <= ack_next;
      proto_err   <= proto_err | err_set;
    end
  end

  assign rd_fire = rd_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      dout  <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (rd_fire) begin
        rptr <= rptr + PTR_W'(1);
        dout <= mem[rptr];
      end
      case ({wr_en, rd_fire})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; the rst term only blocks writes while
  // reset is held.
  always_ff @(posedge clk) begin
    if (wr_en && rst) begin
      mem[wptr] <= data_in;
    end
  end

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

endmodule

// File: tb/tb_handshake_receiver.sv
// tb/tb_handshake_receiver.sv - directed bench for handshake_receiver

module tb_handshake_receiver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       validdata = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       acknowledge;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       proto_err;

  int errors = 0;
  int checks = 0;

  handshake_receiver #(.DATA_W(8), .DEPTH(4), .ACK_DELAY(2)) dut (
    .clk(clk),
    .rst(rst),
    .validdata(validdata),
    .data_in(data_in),
    .acknowledge(acknowledge),
    .rd_en(rd_en),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(count),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    validdata = 1'b0;
    rd_en = 1'b0;
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Complete handshake: capture, bounded wait for acknowledge, release.
  task automatic handshake(input logic [7:0] d);
    bit got;
    validdata = 1'b1;
    data_in = d;
    got = 1'b0;
    tick();
    for (int i = 0; i < 8 && !got; i++) begin
      tick();
      if (acknowledge === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL hs_ack_timeout data=%h ack=%b required 1", d, acknowledge);
    end
    validdata = 1'b0;
    tick();
  endtask

  task automatic read_expect(input logic [7:0] exp, input string name);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL %s dout=%h required %h", name, dout, exp);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({acknowledge, proto_err, empty, full} !== 4'b0010) begin
      errors++;
      $display("FAIL reset_flags ack/err/empty/full=%b required 0010",
               {acknowledge, proto_err, empty, full});
    end
    checks++;
    if (count !== 3'd0 || dout !== 8'h00) begin
      errors++;
      $display("FAIL reset_regs count=%0d dout=%h required 0 00", count, dout);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_empty_read();
    do_reset();
    rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dout !== 8'h00 || count !== 3'd0 || empty !== 1'b1) begin
        errors++;
        $display("FAIL empty_read cyc%0d dout=%h count=%0d empty=%b required 00 0 1",
                 i, dout, count, empty);
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_single();
    validdata = 1'b1;
    data_in = 8'hA5;
    tick();  // t0 capture
    checks++;
    if (acknowledge !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_t0 ack=%b count=%0d required 0 1", acknowledge, count);
    end
    data_in = 8'h00;  // must not matter after capture
    tick();  // t1
    checks++;
    if (acknowledge !== 1'b0) begin
      errors++;
      $display("FAIL single_t1 ack=%b required 0", acknowledge);
    end
    tick();  // t2
    checks++;
    if (acknowledge !== 1'b1) begin
      errors++;
      $display("FAIL single_t2 ack=%b required 1", acknowledge);
    end
    validdata = 1'b0;
    tick();  // t3
    checks++;
    if (acknowledge !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL single_t3 ack=%b count=%0d required 0 1", acknowledge, count);
    end
    read_expect(8'hA5, "single_read");
    checks++;
    if (empty !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL single_empty empty=%b count=%0d required 1 0", empty, count);
    end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 4; i++) handshake(8'(i));
    checks++;
    if (full !== 1'b1 || count !== 3'd4) begin
      errors++;
      $display("FAIL fill_full full=%b count=%0d required 1 4", full, count);
    end
    validdata = 1'b1;
    data_in = 8'h05;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (acknowledge !== 1'b0 || count !== 3'd4) begin
        errors++;
        $display("FAIL fill_backpressure cyc%0d ack=%b count=%0d required 0 4",
                 i, acknowledge, count);
      end
    end
    rd_en = 1'b1;
    tick();  // read edge; capture still blocked
    rd_en = 1'b0;
    checks++;
    if (dout !== 8'h01 || count !== 3'd3 || acknowledge !== 1'b0) begin
      errors++;
      $display("FAIL fill_read dout=%h count=%0d ack=%b required 01 3 0",
               dout, count, acknowledge);
    end
    tick();  // capture 0x05
    checks++;
    if (count !== 3'd4 || acknowledge !== 1'b0) begin
      errors++;
      $display("FAIL fill_retry count=%0d ack=%b required 4 0", count, acknowledge);
    end
    tick();
    checks++;
    if (acknowledge !== 1'b0) begin
      errors++;
      $display("FAIL fill_ack_early ack=%b required 0", acknowledge);
    end
    tick();
    checks++;
    if (acknowledge !== 1'b1) begin
      errors++;
      $display("FAIL fill_ack ack=%b required 1", acknowledge);
    end
    validdata = 1'b0;
    tick();
    read_expect(8'h02, "fill_drain0");
    read_expect(8'h03, "fill_drain1");
    read_expect(8'h04, "fill_drain2");
    read_expect(8'h05, "fill_drain3");
  endtask

  task automatic test_proto();
    validdata = 1'b1;
    data_in = 8'h77;
    tick();  // capture
    validdata = 1'b0;
    tick();  // DELAY sees validdata low
    checks++;
    if (proto_err !== 1'b1 || acknowledge !== 1'b0 || count !== 3'd1) begin
      errors++;
      $display("FAIL proto_flag err=%b ack=%b count=%0d required 1 0 1",
               proto_err, acknowledge, count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (acknowledge !== 1'b0) begin
        errors++;
        $display("FAIL proto_noack cyc%0d ack=%b required 0", i, acknowledge);
      end
    end
    handshake(8'h78);
    checks++;
    if (proto_err !== 1'b1 || count !== 3'd2) begin
      errors++;
      $display("FAIL proto_sticky err=%b count=%0d required 1 2", proto_err, count);
    end
    read_expect(8'h77, "proto_read0");
    read_expect(8'h78, "proto_read1");
  endtask

  task automatic test_simultaneous();
    do_reset();
    handshake(8'h10);
    handshake(8'h11);
    validdata = 1'b1;
    data_in = 8'h12;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (count !== 3'd2 || dout !== 8'h10) begin
      errors++;
      $display("FAIL simul_rw count=%0d dout=%h required 2 10", count, dout);
    end
    tick();
    tick();
    checks++;
    if (acknowledge !== 1'b1) begin
      errors++;
      $display("FAIL simul_ack ack=%b required 1", acknowledge);
    end
    validdata = 1'b0;
    tick();
    read_expect(8'h11, "simul_read1");
    read_expect(8'h12, "simul_read2");
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL simul_empty empty=%b required 1", empty);
    end
  endtask

  task automatic test_reset_mid_ack();
    do_reset();
    validdata = 1'b1;
    data_in = 8'h30;
    tick();
    validdata = 1'b0;
    tick();  // violation, count 1
    handshake(8'h31);
    validdata = 1'b1;
    data_in = 8'h32;
    tick();
    tick();
    tick();
    checks++;
    if (acknowledge !== 1'b1 || count !== 3'd3 || proto_err !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_setup ack=%b count=%0d err=%b required 1 3 1",
               acknowledge, count, proto_err);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (acknowledge !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || proto_err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async ack=%b count=%0d empty=%b err=%b required 0 0 1 0",
               acknowledge, count, empty, proto_err);
    end
    validdata = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (acknowledge !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_release ack=%b count=%0d required 0 0", acknowledge, count);
    end
  endtask

  initial begin
    test_reset();
    test_empty_read();
    test_single();
    test_fill();
    test_proto();
    test_simultaneous();
    test_reset_mid_ack();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
